// File: rtl/sampler_pkg.sv
// Shared definitions for the sampler sequencer: FSM states, tone codes, key bit positions.
// Also holds the one-hot test and the key-to-tone map used by both live monitoring and playback.
package sampler_pkg;

  typedef enum logic [1:0] {
    ST_LIVE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] TONE_Q   = 3'b001;
  localparam logic [2:0] TONE_W   = 3'b010;
  localparam logic [2:0] TONE_E   = 3'b100;
  localparam logic [2:0] TONE_R   = 3'b110;
  localparam logic [2:0] TONE_TO  = 3'b011;
  localparam logic [2:0] TONE_SIL = 3'b000;

  localparam int KEY_Q = 8;
  localparam int KEY_W = 7;
  localparam int KEY_E = 6;
  localparam int KEY_R = 5;

  function automatic logic is_onehot9(input logic [8:0] k);
    return (k != 9'd0) && ((k & (k - 9'd1)) == 9'd0);
  endfunction

  // t/y/u/i/o share one code; chords and silence map to TONE_SIL.
  function automatic logic [2:0] key_to_tone(input logic [8:0] k);
    if (!is_onehot9(k))  return TONE_SIL;
    else if (k[KEY_Q])   return TONE_Q;
    else if (k[KEY_W])   return TONE_W;
    else if (k[KEY_E])   return TONE_E;
    else if (k[KEY_R])   return TONE_R;
    else                 return TONE_TO;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Playback step timer: counts 0..TICK_CYCLES-1 while clear_i is low, held at 0 otherwise.
// tick_o is combinational and marks the last count of each step; no backpressure.
module step_timer #(
  parameter int TICK_CYCLES = 12500000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sampler_sequencer.sv
// Two-track record/playback of one-hot key steps onto a 3-bit tone; every output registered (1 cycle).
// No backpressure. Define LOOP_EN to make playback wrap to step 0 instead of stopping in DONE.
module sampler_sequencer
  import sampler_pkg::*;
#(
  parameter int DEPTH       = 9,
  parameter int TICK_CYCLES = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] keys,
  input  logic [1:0] rec_sel,
  input  logic [1:0] play_en,
  output logic [2:0] tone,
  output logic       grant_b,
  output logic       busy,
  output logic       full,
  output logic [3:0] len_a,
  output logic [3:0] len_b
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  len_a_q, len_a_d, len_b_q, len_b_d, step_q, step_d;
  logic        rec_b_q, rec_b_d;
  logic [8:0]  prev_keys_q;
  logic [2:0]  tone_q, tone_d;
  logic        grant_q, grant_d, busy_q, busy_d, full_q, full_d;

  logic [8:0]  mem_a [DEPTH];
  logic [8:0]  mem_b [DEPTH];

  logic        tick, capture, rec_req, wr_a, wr_b, act_a, act_b, pick_b;
  logic [3:0]  en_len_a, en_len_b, max_len;
  logic [8:0]  play_keys;

  step_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
    .clock_i (clock),
    .reset_i (reset),
    .clear_i (state_q != ST_PLAY),
    .tick_o  (tick)
  );

  // A new step is a fresh one-hot press or a slide to a different single key.
  assign capture  = is_onehot9(keys) && (!is_onehot9(prev_keys_q) || (keys != prev_keys_q));
  assign rec_req  = (rec_sel == 2'b01) || (rec_sel == 2'b10);
  assign en_len_a = play_en[0] ? len_a_q : 4'd0;
  assign en_len_b = play_en[1] ? len_b_q : 4'd0;
  assign max_len  = (en_len_a > en_len_b) ? en_len_a : en_len_b;

  always_comb begin
    state_d = state_q;
    len_a_d = len_a_q;
    len_b_d = len_b_q;
    step_d  = step_q;
    rec_b_d = rec_b_q;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    if ((state_q != ST_REC) && rec_req) begin
      state_d = ST_REC;
      rec_b_d = rec_sel[1];
      if (rec_sel[1]) len_b_d = 4'd0;
      else            len_a_d = 4'd0;
    end else begin
      case (state_q)
        ST_LIVE: begin
          if ((play_en != 2'b00) && (max_len != 4'd0)) begin
            state_d = ST_PLAY;
            step_d  = 4'd0;
          end
        end
        ST_REC: begin
          if (rec_sel != {rec_b_q, !rec_b_q}) begin
            state_d = ST_LIVE;
          end else if (capture) begin
            if (rec_b_q && (len_b_q < DEPTH_L)) begin
              wr_b    = 1'b1;
              len_b_d = len_b_q + 4'd1;
            end else if (!rec_b_q && (len_a_q < DEPTH_L)) begin
              wr_a    = 1'b1;
              len_a_d = len_a_q + 4'd1;
            end
          end
        end
        ST_PLAY: begin
          if (play_en == 2'b00) begin
            state_d = ST_LIVE;
          end else if (tick) begin
            if (({1'b0, step_q} + 5'd1) >= {1'b0, max_len}) begin
`ifdef LOOP_EN
              step_d = 4'd0;
`else
              state_d = ST_DONE;
`endif
            end else begin
              step_d = step_q + 4'd1;
            end
          end
        end
        ST_DONE: if (play_en == 2'b00) state_d = ST_LIVE;
        default: state_d = ST_LIVE;
      endcase
    end
  end

  // Round-robin falls out of step parity: even steps favour A, and every entry/wrap starts at step 0.
  assign act_a     = play_en[0] && (step_d < len_a_q);
  assign act_b     = play_en[1] && (step_d < len_b_q);
  assign pick_b    = act_b && (!act_a || step_d[0]);
  assign play_keys = pick_b ? mem_b[step_d[AW-1:0]] : mem_a[step_d[AW-1:0]];

  always_comb begin
    tone_d  = TONE_SIL;
    grant_d = 1'b0;
    case (state_d)
      ST_LIVE, ST_REC: tone_d = key_to_tone(keys);
      ST_PLAY: begin
        if (act_a || act_b) begin
          tone_d  = key_to_tone(play_keys);
          grant_d = pick_b;
        end
      end
      default: tone_d = TONE_SIL;
    endcase
    busy_d = (state_d == ST_REC) || (state_d == ST_PLAY);
    full_d = (state_d == ST_REC) && ((rec_b_d ? len_b_d : len_a_d) == DEPTH_L);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LIVE;
      len_a_q     <= 4'd0;
      len_b_q     <= 4'd0;
      step_q      <= 4'd0;
      rec_b_q     <= 1'b0;
      prev_keys_q <= 9'd0;
      tone_q      <= TONE_SIL;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_a_q     <= len_a_d;
      len_b_q     <= len_b_d;
      step_q      <= step_d;
      rec_b_q     <= rec_b_d;
      prev_keys_q <= keys;
      tone_q      <= tone_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_a) mem_a[len_a_q[AW-1:0]] <= keys;
    if (wr_b) mem_b[len_b_q[AW-1:0]] <= keys;
  end

  assign tone    = tone_q;
  assign grant_b = grant_q;
  assign busy    = busy_q;
  assign full    = full_q;
  assign len_a   = len_a_q;
  assign len_b   = len_b_q;

endmodule
